seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
- Parallel-in/serial-out stage that feeds the downstream Mealy sequence detector's serial `din` input.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `ser_out`, with a qualifying `ser_valid`.
- Supports back-to-back words with no idle gap, so the detector sees a continuous bit stream.

Parameters:
- WIDTH, 8, bits per word; legal range WIDTH >= 2.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0, level driven on `ser_out` whenever no bit is being sent.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- in_valid  in  1  upstream word is available.
- in_data  in  WIDTH  word to serialise; sampled only on the accept cycle.
- in_ready  out  1  block can accept a word this cycle.
- ser_out  out  1  serial bit, registered; connects to the detector's `din`.
- ser_valid  out  1  `ser_out` carries a payload bit this cycle.
- frame_last  out  1  high with the last bit of each word.
- bit_cnt  out  $clog2(WIDTH)  index of the bit currently on `ser_out`: 0 = first bit sent, WIDTH-1 = last.
- busy  out  1  a word is being shifted.

Behaviour:
- Reset (reset=0, asynchronous, effective immediately and independent of clk):
  - state=ST_IDLE, shift register=0, bit_cnt=0.
  - ser_out=IDLE_BIT, ser_valid=0, frame_last=0, busy=0.
  - in_ready forced to 0 while reset=0.
- FSM has two states.
  - ST_IDLE: in_ready=1. On accept (in_valid & in_ready), load in_data, go to ST_SHIFT, bit_cnt=0.
  - ST_SHIFT: one payload bit per cycle. bit_cnt increments each cycle.
  - On the cycle where bit_cnt=WIDTH-1:
    - if a new word is accepted: reload, stay in ST_SHIFT, bit_cnt=0;
    - otherwise: go to ST_IDLE.
- in_ready is combinational: (state==ST_IDLE) | (state==ST_SHIFT & bit_cnt==WIDTH-1), gated by reset.
- Latency:
  - First bit appears on ser_out in the cycle after the accept edge.
  - A word occupies exactly WIDTH consecutive ser_valid cycles.
  - Back-to-back words produce zero gap cycles.
- Bit order:
  - MSB_FIRST=1: shift left, ser_out = shift register MSB.
  - MSB_FIRST=0: shift right, ser_out = shift register LSB.
- Outputs during ST_SHIFT: ser_valid=1, busy=1, frame_last = (bit_cnt==WIDTH-1).
- Outputs during ST_IDLE: ser_out=IDLE_BIT, ser_valid=0, frame_last=0, busy=0.
- bit_cnt never exceeds WIDTH-1. Non-power-of-two WIDTH wraps explicitly, not via overflow.
- Input handling:
  - in_data and in_valid are ignored when in_ready=0.
  - Upstream may drop in_valid without a transfer; there is no error.
  - Changes to in_data after the accept edge have no effect on the word in flight.
- Reset mid-word: the word is discarded. No partial bits are resumed after reset releases; the block restarts in ST_IDLE.
- No combinational path from in_data to ser_out. The only combinational input-to-output path is reset to in_ready.

Decomposition:
- Shared package `seq_pkg`:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - function clog2 (also used for the bit_cnt width);
  - default WIDTH localparam shared with the detector testbench.
- Single module; no sub-module is warranted. The counter and shifter are inline.

Test Plan:
- Reset check: assert reset=0 mid-simulation -> ser_out=IDLE_BIT, ser_valid=0, busy=0, in_ready=0 immediately, without waiting for a clk edge.
- Single word, MSB_FIRST=1, in_data=8'b1011_0010 accepted at cycle 0:
  - cycles 1..8: ser_out = 1,0,1,1,0,0,1,0 and ser_valid=1;
  - frame_last=1 only at cycle 8;
  - cycle 9: idle.
- Back-to-back words 8'hA5 then 8'h3C, in_valid held high:
  - 16 contiguous ser_valid cycles;
  - in_ready high only at cycles 0 and 8;
  - bit_cnt sequence 0..7, 0..7.
- MSB_FIRST=0, in_data=8'h01 -> ser_out = 1,0,0,0,0,0,0,0.
- Backpressure and mid-word reset:
  - in_valid held high while busy with in_data changing every cycle -> only the data present when in_ready=1 is sent.
  - reset=0 at bit 3 -> output idles; after release, the next accepted word starts at bit_cnt=0.
- Integration with the downstream detector (detector reset driven by the inverted `reset`), in_data=8'b1101_0000 MSB first -> detector dout=1 exactly on the cycle ser_out carries bit index 3; no other pulse in the word.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the downstream sequence detector.
package seq_pkg;

  // Default word width, also used by the detector testbench.
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Ceiling log2, at least 1 so that a counter always has one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out stage feeding the detector's serial input.
// Words are taken over valid/ready. On the last bit of a word a new word
// can be accepted, so back-to-back words leave no gap in the bit stream.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | nothing in flight, ser_out parked at IDLE_BIT, ready for a word
// ST_SHIFT | one payload bit per cycle on ser_out, bit_cnt = index sent
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  localparam int CNT_W    = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_bit;
  logic             accept;
  logic             head_bit;

  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);

  // Ready in idle or on the final bit; reset forces it low without a clock.
  assign in_ready = reset & ((state_q == ST_IDLE) | last_bit);
  assign accept   = in_valid & in_ready;

  assign head_bit = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];

  // Outputs decode from registers only, so in_data never reaches ser_out.
  always_comb begin
    ser_out    = IDLE_BIT;
    ser_valid  = 1'b0;
    frame_last = 1'b0;
    busy       = 1'b0;
    if (state_q == ST_SHIFT) begin
      ser_out    = head_bit;
      ser_valid  = 1'b1;
      frame_last = last_bit;
      busy       = 1'b1;
    end
  end

  assign bit_cnt = cnt_q;

  // Next state: load on accept, shift and count otherwise, wrap at WIDTH-1.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shift_d = in_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d = '0;
          if (accept) begin
            shift_d = in_data;
          end else begin
            shift_d = '0;
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], 1'b0};
          else           shift_d = {1'b0, shift_q[WIDTH-1:1]};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end
    endcase
  end

  // State registers; reset discards any word in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first instance with default
// idle level, plus an LSB-first instance parked high, sharing the inputs.
module tb_seq_bit_serializer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;

  logic       m_in_ready, m_ser_out, m_ser_valid, m_frame_last, m_busy;
  logic [2:0] m_bit_cnt;
  logic       l_in_ready, l_ser_out, l_ser_valid, l_frame_last, l_busy;
  logic [2:0] l_bit_cnt;

  int checks;
  int failures;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(m_in_ready), .ser_out(m_ser_out), .ser_valid(m_ser_valid),
    .frame_last(m_frame_last), .bit_cnt(m_bit_cnt), .busy(m_busy)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) u_lsb (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_in_ready), .ser_out(l_ser_out), .ser_valid(l_ser_valid),
    .frame_last(l_frame_last), .bit_cnt(l_bit_cnt), .busy(l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream Mealy detector looking for 1101.
  logic [2:0] hist;
  logic       det;
  always @(posedge clk or negedge reset) begin
    if (!reset)           hist <= 3'b000;
    else if (m_ser_valid) hist <= {hist[1:0], m_ser_out};
    else                  hist <= 3'b000;
  end
  assign det = m_ser_valid & (hist == 3'b110) & m_ser_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  logic [7:0] w;
  logic [7:0] w2;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset state
    #2;
    chk("rst_in_ready", m_in_ready, 1'b0);
    chk("rst_ser_out", m_ser_out, 1'b0);
    chk("rst_ser_valid", m_ser_valid, 1'b0);
    chk("rst_busy", m_busy, 1'b0);
    chk("rst_bit_cnt", m_bit_cnt, 3'd0);
    chk("rst_lsb_idle", l_ser_out, 1'b1);
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("idle_in_ready", m_in_ready, 1'b1);

    // Single word, MSB first; LSB instance takes the same word
    tick();
    w        = 8'b1011_0010;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    chk("w1_accept_ready", m_in_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) begin
        in_valid = 1'b0;
        in_data  = 8'h00;
      end
      chk($sformatf("w1_bit%0d", k), m_ser_out, w[8-k]);
      chk($sformatf("w1_valid%0d", k), m_ser_valid, 1'b1);
      chk($sformatf("w1_last%0d", k), m_frame_last, (k == 8));
      chk($sformatf("w1_cnt%0d", k), m_bit_cnt, k - 1);
      chk($sformatf("w1_busy%0d", k), m_busy, 1'b1);
      chk($sformatf("w1_ready%0d", k), m_in_ready, (k == 8));
      chk($sformatf("w1_lsb_bit%0d", k), l_ser_out, w[k-1]);
    end
    tick();
    chk("w1_idle_valid", m_ser_valid, 1'b0);
    chk("w1_idle_out", m_ser_out, 1'b0);
    chk("w1_idle_busy", m_busy, 1'b0);
    chk("w1_idle_last", m_frame_last, 1'b0);
    chk("w1_lsb_idle_out", l_ser_out, 1'b1);

    // LSB first, 8'h01
    tick();
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int k = 1; k <= 8; k++) begin
      tick();
      in_valid = 1'b0;
      chk($sformatf("lsb01_bit%0d", k), l_ser_out, (k == 1));
      chk($sformatf("lsb01_cnt%0d", k), l_bit_cnt, k - 1);
    end
    tick();
    chk("lsb01_idle", l_ser_valid, 1'b0);

    // Back-to-back A5 then 3C, garbage data held valid while busy
    tick();
    w        = 8'hA5;
    w2       = 8'h3C;
    in_valid = 1'b1;
    in_data  = w;
    #1;
    chk("b2b_ready0", m_in_ready, 1'b1);
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("b2b_valid%0d", c), m_ser_valid, 1'b1);
      chk($sformatf("b2b_cnt%0d", c), m_bit_cnt, (c - 1) % 8);
      chk($sformatf("b2b_bit%0d", c), m_ser_out, (c <= 8) ? w[8-c] : w2[16-c]);
      if (c <= 15) chk($sformatf("b2b_ready%0d", c), m_in_ready, (c == 8));
      if (c == 8)      in_data = w2;
      else if (c < 8)  in_data = 8'(c * 8'h11 + 8'h5A);
      else begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
      end
    end
    tick();
    chk("b2b_gap_end", m_ser_valid, 1'b0);

    // Mid-word reset at bit 3, then restart from bit_cnt 0
    tick();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      in_data = 8'h81;
    end
    chk("mrst_cnt3", m_bit_cnt, 3'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("mrst_valid", m_ser_valid, 1'b0);
    chk("mrst_busy", m_busy, 1'b0);
    chk("mrst_ready", m_in_ready, 1'b0);
    chk("mrst_out", m_ser_out, 1'b0);
    chk("mrst_cnt", m_bit_cnt, 3'd0);
    tick();
    chk("mrst_held_valid", m_ser_valid, 1'b0);
    reset = 1'b1;
    #1;
    chk("mrst_rel_ready", m_in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("mrst_new_cnt0", m_bit_cnt, 3'd0);
    chk("mrst_new_bit0", m_ser_out, 1'b1);
    tick();
    chk("mrst_new_cnt1", m_bit_cnt, 3'd1);
    chk("mrst_new_bit1", m_ser_out, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    chk("mrst_drained", m_ser_valid, 1'b0);

    // Detector integration, 1101_0000 MSB first: pulse only at bit 3
    tick();
    in_valid = 1'b1;
    in_data  = 8'b1101_0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      in_valid = 1'b0;
      chk($sformatf("det_bit%0d", k - 1), det, (k == 4));
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
